// File: rtl/ewtag_offset_ctrl_pkg.sv
// Shared parameters for the event-window tag tracker: tag width and FSM encoding.
package ewtag_offset_ctrl_pkg;

  localparam int unsigned EVENT_TAG_BITS = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

endpackage

// File: rtl/ewtag_offset_ctrl_offset_switch.sv
// Offset source select: the serial value as-is, or the run tag minus one (wrapping).
module offset_switch #(
  parameter int unsigned TAG_W = 16
) (
  input  logic             serial_sel,
  input  logic [TAG_W-1:0] serial_val,
  input  logic [TAG_W-1:0] run_offset,
  output logic [TAG_W-1:0] offset
);

  always_comb begin
    offset = serial_sel ? serial_val : run_offset - TAG_W'(1);
  end

endmodule

// File: rtl/ewtag_offset_ctrl.sv
// Event-window tag offset controller: tracks spills via heartbeats and publishes a
// registered offset taken from either the run start tag or a serially loaded value.
module ewtag_offset_ctrl
  import ewtag_offset_ctrl_pkg::*;
#(
  parameter int unsigned TAG_W = EVENT_TAG_BITS,
  parameter int unsigned ERR_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             hb_valid,
  input  logic [TAG_W-1:0] hb_tag,
  input  logic             hb_spill_start,
  input  logic             spill_end,
  input  logic             serial_en,
  input  logic             serial_load,
  input  logic [TAG_W-1:0] serial_offset,
  output logic [TAG_W-1:0] ewtag_offset,
  output logic             offset_valid,
  output logic             offset_update,
  output logic [ERR_W-1:0] hb_gap_err,
  output logic [1:0]       state
);

  state_e             state_q, state_d;
  logic [TAG_W-1:0]   run_offset_q, run_offset_d;
  logic [TAG_W-1:0]   last_tag_q, last_tag_d;
  logic [TAG_W-1:0]   pend_val_q, pend_val_d;
  logic               pend_q, pend_d;
  logic [TAG_W-1:0]   act_val_q, act_val_d;
  logic               act_q, act_d;
  logic               sel_q, sel_d;
  logic               src_q, src_d;
  logic [TAG_W-1:0]   offset_q, offset_d;
  logic               valid_q, valid_d;
  logic               update_q, update_d;
  logic [ERR_W-1:0]   err_q, err_d;

  logic               hb_eff, start_run, commit, load;
  logic [TAG_W-1:0]   tag_next;
  logic [TAG_W-1:0]   sw_offset;

  always_comb begin
    state_d      = state_q;
    run_offset_d = run_offset_q;
    last_tag_d   = last_tag_q;
    pend_val_d   = pend_val_q;
    pend_d       = pend_q;
    act_val_d    = act_val_q;
    act_d        = act_q;
    sel_d        = sel_q;
    err_d        = err_q;
    start_run    = 1'b0;
    commit       = 1'b0;
    // spill_end takes priority: a coincident heartbeat is dropped entirely
    hb_eff       = hb_valid & ~spill_end;
    tag_next     = last_tag_q + TAG_W'(1);

    case (state_q)
      ST_IDLE:  state_d = ST_ARMED;
      ST_ARMED: begin
        commit = 1'b1;
        if (hb_eff && hb_spill_start) begin
          state_d   = ST_RUN;
          start_run = 1'b1;
          err_d     = '0;
        end
      end
      ST_RUN: begin
        if (spill_end) begin
          state_d = ST_ARMED;
        end else if (hb_valid) begin
          commit = 1'b1;
          if (hb_spill_start) begin
            start_run = 1'b1;
          end else if (hb_tag != tag_next && err_q != '1) begin
            err_d = err_q + ERR_W'(1);
          end
        end
      end
      default:  state_d = ST_IDLE;
    endcase

    if (hb_eff)
      last_tag_d = hb_tag;
    if (start_run)
      run_offset_d = hb_tag;

    // Loading before committing lets a same-cycle serial_load land on this boundary
    if (serial_load) begin
      pend_val_d = serial_offset;
      pend_d     = 1'b1;
    end
    if (commit) begin
      sel_d = serial_en;
      if (pend_d) begin
        act_val_d = pend_val_d;
        act_d     = 1'b1;
        pend_d    = 1'b0;
      end
    end

    load    = (state_q == ST_ARMED && (start_run || (sel_d && act_d))) ||
              (state_q == ST_RUN && commit);
    valid_d = (state_d == ST_RUN) || (state_d == ST_ARMED && sel_d && act_d);
  end

  offset_switch #(
    .TAG_W(TAG_W)
  ) u_offset_switch (
    .serial_sel (sel_d),
    .serial_val (act_val_d),
    .run_offset (run_offset_d),
    .offset     (sw_offset)
  );

  always_comb begin
    offset_d = offset_q;
    src_d    = src_q;
    update_d = 1'b0;
    if (load) begin
      offset_d = sw_offset;
      src_d    = sel_d;
      update_d = (sw_offset != offset_q) || (sel_d != src_q);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      run_offset_q <= '0;
      last_tag_q   <= '0;
      pend_val_q   <= '0;
      pend_q       <= 1'b0;
      act_val_q    <= '0;
      act_q        <= 1'b0;
      sel_q        <= 1'b0;
      src_q        <= 1'b0;
      offset_q     <= '0;
      valid_q      <= 1'b0;
      update_q     <= 1'b0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      run_offset_q <= run_offset_d;
      last_tag_q   <= last_tag_d;
      pend_val_q   <= pend_val_d;
      pend_q       <= pend_d;
      act_val_q    <= act_val_d;
      act_q        <= act_d;
      sel_q        <= sel_d;
      src_q        <= src_d;
      offset_q     <= offset_d;
      valid_q      <= valid_d;
      update_q     <= update_d;
      err_q        <= err_d;
    end
  end

  assign ewtag_offset  = offset_q;
  assign offset_valid  = valid_q;
  assign offset_update = update_q;
  assign hb_gap_err    = err_q;
  assign state         = state_q;

endmodule

// File: tb/tb_ewtag_offset_ctrl.sv
// Directed bench for ewtag_offset_ctrl with hand-computed expectations (TAG_W=16, ERR_W=8).
module tb_ewtag_offset_ctrl;

  localparam int unsigned TW = 16;
  localparam int unsigned EW = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          hb_valid;
  logic [TW-1:0] hb_tag;
  logic          hb_spill_start;
  logic          spill_end;
  logic          serial_en;
  logic          serial_load;
  logic [TW-1:0] serial_offset;
  logic [TW-1:0] ewtag_offset;
  logic          offset_valid;
  logic          offset_update;
  logic [EW-1:0] hb_gap_err;
  logic [1:0]    state;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  ewtag_offset_ctrl #(
    .TAG_W(TW),
    .ERR_W(EW)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .hb_valid       (hb_valid),
    .hb_tag         (hb_tag),
    .hb_spill_start (hb_spill_start),
    .spill_end      (spill_end),
    .serial_en      (serial_en),
    .serial_load    (serial_load),
    .serial_offset  (serial_offset),
    .ewtag_offset   (ewtag_offset),
    .offset_valid   (offset_valid),
    .offset_update  (offset_update),
    .hb_gap_err     (hb_gap_err),
    .state          (state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_strobes();
    hb_valid       = 1'b0;
    hb_spill_start = 1'b0;
    spill_end      = 1'b0;
    serial_load    = 1'b0;
  endtask

  task automatic check_all(input string tag, input logic [1:0] st, input logic [TW-1:0] off,
                           input logic vld, input logic upd, input logic [EW-1:0] err);
    chk({tag, ".state"}, 32'(state), 32'(st));
    chk({tag, ".offset"}, 32'(ewtag_offset), 32'(off));
    chk({tag, ".valid"}, 32'(offset_valid), 32'(vld));
    chk({tag, ".update"}, 32'(offset_update), 32'(upd));
    chk({tag, ".gap_err"}, 32'(hb_gap_err), 32'(err));
  endtask

  initial begin
    reset_n       = 1'b0;
    hb_tag        = '0;
    serial_en     = 1'b0;
    serial_offset = '0;
    clear_strobes();
    #3;
    check_all("reset", 2'd0, 16'h0000, 1'b0, 1'b0, 8'h00);

    @(posedge clk);
    #3 reset_n = 1'b1;
    tick();
    check_all("armed", 2'd1, 16'h0000, 1'b0, 1'b0, 8'h00);

    // Spill start at 0x100 -> offset 0xFF
    hb_valid = 1'b1; hb_spill_start = 1'b1; hb_tag = 16'h0100;
    tick(); clear_strobes();
    check_all("start100", 2'd2, 16'h00FF, 1'b1, 1'b1, 8'h00);
    hb_valid = 1'b1; hb_tag = 16'h0101;
    tick(); clear_strobes();
    check_all("hb101", 2'd2, 16'h00FF, 1'b1, 1'b0, 8'h00);

    spill_end = 1'b1;
    tick(); clear_strobes();
    check_all("end1", 2'd1, 16'h00FF, 1'b0, 1'b0, 8'h00);

    // Tags 5,6,8 -> one gap
    hb_valid = 1'b1; hb_spill_start = 1'b1; hb_tag = 16'd5;
    tick(); clear_strobes();
    check_all("start5", 2'd2, 16'h0004, 1'b1, 1'b1, 8'h00);
    hb_valid = 1'b1; hb_tag = 16'd6;
    tick(); clear_strobes();
    chk("hb6.gap_err", 32'(hb_gap_err), 32'h0);
    hb_valid = 1'b1; hb_tag = 16'd8;
    tick(); clear_strobes();
    check_all("hb8", 2'd2, 16'h0004, 1'b1, 1'b0, 8'h01);

    // spill_end beats a coincident heartbeat
    spill_end = 1'b1; hb_valid = 1'b1; hb_tag = 16'd20;
    tick(); clear_strobes();
    check_all("end_hb", 2'd1, 16'h0004, 1'b0, 1'b0, 8'h01);

    // Spill start at tag 0 wraps; gap counter cleared
    hb_valid = 1'b1; hb_spill_start = 1'b1; hb_tag = 16'd0;
    tick(); clear_strobes();
    check_all("start0", 2'd2, 16'hFFFF, 1'b1, 1'b1, 8'h00);

    // Repeated tag 0 is a gap every time; saturate the counter
    hb_valid = 1'b1; hb_tag = 16'd0;
    for (int i = 0; i < 254; i++) tick();
    hb_valid = 1'b0;
    chk("sat254.gap_err", 32'(hb_gap_err), 32'hFE);
    hb_valid = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    clear_strobes();
    check_all("sat259", 2'd2, 16'hFFFF, 1'b1, 1'b0, 8'hFF);

    // Serial enable and load mid-window wait for the next heartbeat
    serial_en = 1'b1;
    tick();
    check_all("sen_mid", 2'd2, 16'hFFFF, 1'b1, 1'b0, 8'hFF);
    serial_load = 1'b1; serial_offset = 16'h0055;
    tick(); clear_strobes();
    tick();
    check_all("load55_mid", 2'd2, 16'hFFFF, 1'b1, 1'b0, 8'hFF);
    hb_valid = 1'b1; hb_tag = 16'd1;
    tick(); clear_strobes();
    check_all("commit55", 2'd2, 16'h0055, 1'b1, 1'b1, 8'hFF);
    tick();
    chk("after55.update", 32'(offset_update), 32'h0);

    // Load coincident with heartbeat commits at that boundary
    serial_load = 1'b1; serial_offset = 16'h0077; hb_valid = 1'b1; hb_tag = 16'd2;
    tick(); clear_strobes();
    check_all("load77_hb", 2'd2, 16'h0077, 1'b1, 1'b1, 8'hFF);

    // Back to run-derived source, again only at a heartbeat
    serial_en = 1'b0;
    tick();
    check_all("sdis_mid", 2'd2, 16'h0077, 1'b1, 1'b0, 8'hFF);
    hb_valid = 1'b1; hb_tag = 16'd3;
    tick(); clear_strobes();
    check_all("sdis_hb", 2'd2, 16'hFFFF, 1'b1, 1'b1, 8'hFF);

    // In ARMED, serial changes act immediately
    spill_end = 1'b1;
    tick(); clear_strobes();
    check_all("end2", 2'd1, 16'hFFFF, 1'b0, 1'b0, 8'hFF);
    serial_en = 1'b1;
    tick();
    check_all("armed_sen", 2'd1, 16'h0077, 1'b1, 1'b1, 8'hFF);
    serial_load = 1'b1; serial_offset = 16'h0033;
    tick(); clear_strobes();
    check_all("armed_load33", 2'd1, 16'h0033, 1'b1, 1'b1, 8'hFF);
    serial_en = 1'b0;
    tick();
    check_all("armed_sdis", 2'd1, 16'h0033, 1'b0, 1'b0, 8'hFF);

    hb_valid = 1'b1; hb_spill_start = 1'b1; hb_tag = 16'h0010;
    tick(); clear_strobes();
    check_all("start10", 2'd2, 16'h000F, 1'b1, 1'b1, 8'h00);
    hb_valid = 1'b1; hb_tag = 16'h0020;
    tick(); clear_strobes();
    check_all("hb20", 2'd2, 16'h000F, 1'b1, 1'b0, 8'h01);

    // Asynchronous reset between clock edges
    #2 reset_n = 1'b0;
    #1;
    check_all("async_rst", 2'd0, 16'h0000, 1'b0, 1'b0, 8'h00);
    tick();
    chk("rst_hold.state", 32'(state), 32'h0);
    #2 reset_n = 1'b1;
    tick();
    check_all("post_rst", 2'd1, 16'h0000, 1'b0, 1'b0, 8'h00);
    serial_en = 1'b1;
    tick();
    check_all("post_rst_sen", 2'd1, 16'h0000, 1'b0, 1'b0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
